puf_uart_ctrl: RTL and testbench

Command sequencer between the host UART byte interface and the PUF core. It parses host command bytes delivered by the UART receiver, collects challenge bytes, and starts one PUF evaluation. It then serialises a status byte and the response bytes back through the UART transmitter handshake. It is the only master of the UART TX side and the only driver of the PUF start/challenge inputs.

---
 rtl/puf_uart_ctrl.sv | 170 +++++++++++++++++
 tb/tb_puf_uart_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/puf_uart_ctrl.sv
// PUF command sequencer: parses host UART commands, loads the challenge,
// runs one PUF evaluation and streams status plus response bytes back.
module puf_uart_ctrl #(
  parameter int CHAL_BYTES       = 8,
  parameter int RESP_BYTES       = 4,
  parameter int RX_TIMEOUT_CLKS  = 1200000,
  parameter int PUF_TIMEOUT_CLKS = 65535
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              rx_data,
  input  logic                    rx_rdy,
  input  logic                    tx_rdy,
  output logic [7:0]              tx_data,
  output logic                    tx_start,
  output logic [8*CHAL_BYTES-1:0] puf_challenge,
  output logic                    puf_start,
  input  logic                    puf_done,
  input  logic [8*RESP_BYTES-1:0] puf_response,
  output logic                    busy
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RXCH = 3'd1;
  localparam logic [2:0] S_PSTA = 3'd2;
  localparam logic [2:0] S_PRUN = 3'd3;
  localparam logic [2:0] S_SEND = 3'd4;
  localparam logic [2:0] S_PULS = 3'd5;
  localparam logic [2:0] S_WAIT = 3'd6;

  localparam logic [7:0] CMD_C = 8'h43;
  localparam logic [7:0] CMD_P = 8'h50;
  localparam logic [7:0] RPL_A = 8'h41;
  localparam logic [7:0] RPL_Q = 8'h3F;
  localparam logic [7:0] RPL_T = 8'h54;

  localparam logic [20:0] RX_LAST  = 21'(RX_TIMEOUT_CLKS - 1);
  localparam logic [20:0] PUF_LAST = 21'(PUF_TIMEOUT_CLKS - 1);
  localparam logic [4:0]  IDX_LAST = 5'(CHAL_BYTES - 1);
  localparam logic [4:0]  RESP_N   = 5'(RESP_BYTES);

  logic [2:0]              state_q, state_d;
  logic [20:0]             timer_q, timer_d;
  logic [4:0]              idx_q, idx_d;
  logic [4:0]              cnt_q, cnt_d;
  logic [7:0]              tx_data_q, tx_data_d;
  logic                    tx_start_q, tx_start_d;
  logic                    puf_start_q, puf_start_d;
  logic                    busy_q, busy_d;
  logic [8*CHAL_BYTES-1:0] chal_q, chal_d;
  logic [8*RESP_BYTES-1:0] resp_q, resp_d;

  assign tx_data       = tx_data_q;
  assign tx_start      = tx_start_q;
  assign puf_start     = puf_start_q;
  assign puf_challenge = chal_q;
  assign busy          = busy_q;

  // Next-state logic; pulses default low, timer free-runs and is cleared on entry.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q + 21'd1;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    tx_data_d   = tx_data_q;
    tx_start_d  = 1'b0;
    puf_start_d = 1'b0;
    chal_d      = chal_q;
    resp_d      = resp_q;
    unique case (state_q)
      S_IDLE: begin
        timer_d = '0;
        if (rx_rdy) begin
          if (rx_data == CMD_C) begin
            idx_d   = '0;
            state_d = S_RXCH;
          end else begin
            tx_data_d = (rx_data == CMD_P) ? CMD_P : RPL_Q;
            cnt_d     = '0;
            state_d   = S_SEND;
          end
        end
      end
      S_RXCH: begin
        if (rx_rdy) begin
          for (int k = 0; k < CHAL_BYTES; k++) begin
            if (idx_q == 5'(k)) chal_d[8*k +: 8] = rx_data;
          end
          timer_d = '0;
          idx_d   = idx_q + 5'd1;
          if (idx_q == IDX_LAST) begin
            puf_start_d = 1'b1;
            state_d     = S_PSTA;
          end
        end else if (timer_q == RX_LAST) begin
          tx_data_d = RPL_T;
          cnt_d     = '0;
          state_d   = S_SEND;
        end
      end
      S_PSTA: begin
        timer_d = '0;
        state_d = S_PRUN;
      end
      S_PRUN: begin
        if (puf_done) begin
          resp_d    = puf_response;
          tx_data_d = RPL_A;
          cnt_d     = RESP_N;
          state_d   = S_SEND;
        end else if (timer_q == PUF_LAST) begin
          tx_data_d = RPL_T;
          cnt_d     = '0;
          state_d   = S_SEND;
        end
      end
      S_SEND: begin
        if (tx_rdy) begin
          tx_start_d = 1'b1;
          state_d    = S_PULS;
        end
      end
      S_PULS: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (tx_rdy) begin
          if (cnt_q != 5'd0) begin
            tx_data_d = resp_q[7:0];
            resp_d    = resp_q >> 8;
            cnt_d     = cnt_q - 5'd1;
            state_d   = S_SEND;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs; reset abandons any frame or evaluation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      tx_data_q   <= '0;
      tx_start_q  <= 1'b0;
      puf_start_q <= 1'b0;
      busy_q      <= 1'b0;
      chal_q      <= '0;
      resp_q      <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      tx_data_q   <= tx_data_d;
      tx_start_q  <= tx_start_d;
      puf_start_q <= puf_start_d;
      busy_q      <= busy_d;
      chal_q      <= chal_d;
      resp_q      <= resp_d;
    end
  end

endmodule

// File: tb/tb_puf_uart_ctrl.sv
// Scoreboard bench for puf_uart_ctrl with UART TX and PUF responder models.
module tb_puf_uart_ctrl;

  localparam int RXT   = 40;
  localparam int PT    = 30;
  localparam int TXLEN = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_rdy;
  logic        tx_rdy;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic [63:0] puf_challenge;
  logic        puf_start;
  logic        puf_done;
  logic [31:0] puf_response;
  logic        busy;

  puf_uart_ctrl #(
    .CHAL_BYTES(8), .RESP_BYTES(4),
    .RX_TIMEOUT_CLKS(RXT), .PUF_TIMEOUT_CLKS(PT)
  ) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_rdy(rx_rdy),
    .tx_rdy(tx_rdy), .tx_data(tx_data), .tx_start(tx_start),
    .puf_challenge(puf_challenge), .puf_start(puf_start),
    .puf_done(puf_done), .puf_response(puf_response), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  int tx_cnt = 0;
  int last_tx_cyc = 0;
  int last_rx_cyc = 0;
  int puf_starts = 0;
  int puf_start_cyc = 0;
  int done_cyc = 0;
  int puf_mode = 0;

  task automatic check(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask

  // UART TX model: drops tx_rdy the cycle after tx_start, idle again after TXLEN cycles.
  initial begin
    tx_rdy = 1'b1;
    forever begin
      @(negedge clk);
      if (tx_start === 1'b1 && !rst) begin
        @(posedge clk);
        #1 tx_rdy = 1'b0;
        repeat (TXLEN - 1) @(posedge clk);
        #1 tx_rdy = 1'b1;
      end
    end
  end

  // PUF model: mode 0 done after 10 cycles, mode 1 never, mode 2 on the expiry cycle.
  initial begin
    puf_done = 1'b0;
    puf_response = '0;
    forever begin
      @(negedge clk);
      if (puf_start === 1'b1) begin
        puf_starts++;
        puf_start_cyc = cyc;
        if (puf_mode == 0) begin
          repeat (10) @(posedge clk);
          #1 puf_response = 32'hDDCCBBAA; puf_done = 1'b1; done_cyc = cyc;
          @(posedge clk);
          #1 puf_done = 1'b0;
        end else if (puf_mode == 2) begin
          repeat (PT) @(posedge clk);
          #1 puf_response = 32'h44332211; puf_done = 1'b1; done_cyc = cyc;
          @(posedge clk);
          #1 puf_done = 1'b0;
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every tx_start and checks the handshake.
  logic       prev_start = 1'b0;
  logic       frame_act = 1'b0;
  logic       frame_bad = 1'b0;
  logic       seen_low = 1'b0;
  logic       gap_pend = 1'b0;
  logic [7:0] frame_dat = '0;
  logic [7:0] exp_b;
  int         frame_end_cyc = 0;

  always @(negedge clk) begin
    if (rst) begin
      frame_act = 1'b0;
      prev_start = 1'b0;
      gap_pend = 1'b0;
    end else begin
      if (tx_start) begin
        check("tx_start_back_to_back", {63'd0, prev_start}, 64'd0);
        check("tx_start_while_busy_tx", {63'd0, tx_rdy}, 64'd1);
        if (gap_pend) check("tx_gap", 64'(cyc), 64'(frame_end_cyc + 2));
        gap_pend = 1'b0;
        tx_cnt++;
        last_tx_cyc = cyc;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL tx_unexpected: got %0h, expected no byte", tx_data);
        end else begin
          exp_b = exp_q.pop_front();
          check("tx_byte", {56'd0, tx_data}, {56'd0, exp_b});
        end
        frame_act = 1'b1;
        frame_dat = tx_data;
        frame_bad = 1'b0;
        seen_low = 1'b0;
      end else if (frame_act) begin
        if (tx_data !== frame_dat) frame_bad = 1'b1;
        if (!tx_rdy) begin
          seen_low = 1'b1;
        end else if (seen_low) begin
          check("tx_data_stable", {63'd0, frame_bad}, 64'd0);
          frame_act = 1'b0;
          frame_end_cyc = cyc;
          gap_pend = (exp_q.size() != 0);
        end
      end
      prev_start = tx_start;
    end
  end

  task automatic send(input logic [7:0] b);
    @(posedge clk);
    #1 rx_data = b; rx_rdy = 1'b1; last_rx_cyc = cyc;
    @(posedge clk);
    #1 rx_rdy = 1'b0;
  endtask

  task automatic send_chal(input logic [7:0] base);
    send(8'h43);
    for (int i = 0; i < 8; i++) send(base + 8'(i));
  endtask

  task automatic wait_idle(input int budget);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    check("wait_idle_bound", {63'd0, ok}, 64'd1);
  endtask

  task automatic wait_tx(input int target, input int budget);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (tx_cnt >= target) begin
        ok = 1'b1;
        break;
      end
    end
    check("wait_tx_bound", {63'd0, ok}, 64'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, expected end of run");
    $fatal(1);
  end

  int base_tx;
  int base_ps;

  initial begin
    rst = 1'b1;
    rx_data = '0;
    rx_rdy = 1'b0;
    #2;
    check("rst_tx_data", {56'd0, tx_data}, 64'd0);
    check("rst_tx_start", {63'd0, tx_start}, 64'd0);
    check("rst_puf_start", {63'd0, puf_start}, 64'd0);
    check("rst_challenge", puf_challenge, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Ping: reply 2 cycles after the command, busy held across the frame.
    base_tx = tx_cnt;
    exp_q.push_back(8'h50);
    send(8'h50);
    wait_tx(base_tx + 1, 20);
    check("ping_latency", 64'(last_tx_cyc), 64'(last_rx_cyc + 2));
    @(negedge clk);
    @(negedge clk);
    check("ping_busy_in_frame", {63'd0, busy}, 64'd1);
    wait_idle(50);
    check("ping_tx_rdy_before_idle", {63'd0, tx_rdy}, 64'd1);

    // Unknown command; rx pulses during the reply must be dropped.
    base_tx = tx_cnt;
    exp_q.push_back(8'h3F);
    send(8'h7A);
    send(8'h50);
    wait_tx(base_tx + 1, 20);
    @(negedge clk);
    @(negedge clk);
    send(8'h43);
    wait_idle(50);
    repeat (20) @(negedge clk);
    check("unknown_single_reply", 64'(tx_cnt), 64'(base_tx + 1));
    check("unknown_back_idle", {63'd0, busy}, 64'd0);

    // Full challenge evaluation.
    puf_mode = 0;
    base_ps = puf_starts;
    base_tx = tx_cnt;
    exp_q.push_back(8'h41);
    exp_q.push_back(8'hAA);
    exp_q.push_back(8'hBB);
    exp_q.push_back(8'hCC);
    exp_q.push_back(8'hDD);
    send_chal(8'h01);
    wait_tx(base_tx + 1, 40);
    check("puf_start_latency", 64'(puf_start_cyc), 64'(last_rx_cyc + 1));
    check("done_to_tx_start", 64'(last_tx_cyc), 64'(done_cyc + 2));
    wait_idle(200);
    check("chal_value", puf_challenge, 64'h0807060504030201);
    check("one_puf_start", 64'(puf_starts), 64'(base_ps + 1));
    check("c_reply_len", 64'(tx_cnt), 64'(base_tx + 5));

    // Challenge timeout after 3 bytes: decision edge RXT cycles after the
    // last byte, then one cycle in TX_SEND before tx_start.
    base_ps = puf_starts;
    exp_q.push_back(8'h54);
    send(8'h43);
    send(8'h11);
    send(8'h22);
    send(8'h33);
    wait_idle(200);
    check("rx_timeout_time", 64'(last_tx_cyc), 64'(last_rx_cyc + RXT + 2));
    check("chal_partial", puf_challenge, 64'h0807060504332211);
    check("rx_timeout_no_puf", 64'(puf_starts), 64'(base_ps));

    // PUF never answers.
    puf_mode = 1;
    exp_q.push_back(8'h54);
    send_chal(8'h01);
    wait_idle(200);
    check("puf_timeout_time", 64'(last_tx_cyc), 64'(puf_start_cyc + PT + 2));

    // puf_done on the expiry cycle wins.
    puf_mode = 2;
    base_tx = tx_cnt;
    exp_q.push_back(8'h41);
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    exp_q.push_back(8'h33);
    exp_q.push_back(8'h44);
    send_chal(8'h01);
    wait_idle(300);
    check("collision_reply_len", 64'(tx_cnt), 64'(base_tx + 5));

    // Reset while waiting on the second reply frame.
    puf_mode = 0;
    base_tx = tx_cnt;
    exp_q.push_back(8'h41);
    exp_q.push_back(8'hAA);
    exp_q.push_back(8'hBB);
    exp_q.push_back(8'hCC);
    exp_q.push_back(8'hDD);
    send_chal(8'h01);
    wait_tx(base_tx + 2, 100);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_tx_data", {56'd0, tx_data}, 64'd0);
    check("mid_rst_tx_start", {63'd0, tx_start}, 64'd0);
    check("mid_rst_puf_start", {63'd0, puf_start}, 64'd0);
    check("mid_rst_challenge", puf_challenge, 64'd0);
    check("mid_rst_busy", {63'd0, busy}, 64'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    base_tx = tx_cnt;
    exp_q.push_back(8'h50);
    send(8'h50);
    wait_idle(100);
    check("post_rst_ping", 64'(tx_cnt), 64'(base_tx + 1));

    repeat (5) @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
